// File: rtl/id_ex_pipe_reg_if.sv
// id_ex_pipe_reg_if: ID-side inputs, hazard controls and EX-side outputs of the ID/EX register
interface id_ex_pipe_reg_if #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
);
   logic             Ctrl, hold, flush, valid_ID;
   logic [XLEN-1:0]  pc_ID, rs1_data_ID, rs2_data_ID, imm_ID;
   logic [4:0]       rs1_ID, rs2_ID, rd_ID;
   logic [8:0]       ctrl_ID;
   logic [3:0]       funct_ID;
   logic             valid_EX;
   logic [XLEN-1:0]  pc_EX, rs1_data_EX, rs2_data_EX, imm_EX;
   logic [4:0]       rs1_EX, rs2_EX, rd_EX;
   logic             RegWrite_EX, MemRead_EX, MemWrite_EX, MemToReg_EX, ALUSrc_EX, Branch_EX, Jump_EX;
   logic [1:0]       ALUOp_EX;
   logic [3:0]       funct_EX;
   logic [CNT_W-1:0] bubble_cnt, flush_cnt;
   modport master (
      output Ctrl, hold, flush, valid_ID, pc_ID, rs1_data_ID, rs2_data_ID, imm_ID,
             rs1_ID, rs2_ID, rd_ID, ctrl_ID, funct_ID,
      input  valid_EX, pc_EX, rs1_data_EX, rs2_data_EX, imm_EX, rs1_EX, rs2_EX, rd_EX,
             RegWrite_EX, MemRead_EX, MemWrite_EX, MemToReg_EX, ALUSrc_EX, Branch_EX, Jump_EX,
             ALUOp_EX, funct_EX, bubble_cnt, flush_cnt
   );
   modport slave (
      input  Ctrl, hold, flush, valid_ID, pc_ID, rs1_data_ID, rs2_data_ID, imm_ID,
             rs1_ID, rs2_ID, rd_ID, ctrl_ID, funct_ID,
      output valid_EX, pc_EX, rs1_data_EX, rs2_data_EX, imm_EX, rs1_EX, rs2_EX, rd_EX,
             RegWrite_EX, MemRead_EX, MemWrite_EX, MemToReg_EX, ALUSrc_EX, Branch_EX, Jump_EX,
             ALUOp_EX, funct_EX, bubble_cnt, flush_cnt
   );
endinterface

// File: rtl/id_ex_pipe_reg.sv
// id_ex_pipe_reg: ID/EX pipeline register with bubble/hold/flush and saturating event counters
module id_ex_pipe_reg #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
) (
   input logic           clk,
   input logic           rst_n,
   id_ex_pipe_reg_if.slave bus
);
   logic live, load, bump_b, bump_f;
   // live: the ID instruction survives into EX; load: the register advances this edge
   always_comb begin
      live   = bus.valid_ID & ~bus.flush & ~bus.Ctrl;
      load   = bus.flush | ~bus.hold;
      bump_b = ~bus.flush & ~bus.hold & bus.Ctrl & ~(&bus.bubble_cnt);
      bump_f = bus.flush & ~(&bus.flush_cnt);
   end
   // pipeline fields; killed slots zero control and rd_EX so the hazard unit never re-triggers on them
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.valid_EX    <= 1'b0;
         bus.pc_EX       <= '0;
         bus.rs1_data_EX <= '0;
         bus.rs2_data_EX <= '0;
         bus.imm_EX      <= '0;
         bus.rs1_EX      <= '0;
         bus.rs2_EX      <= '0;
         bus.rd_EX       <= '0;
         bus.funct_EX    <= '0;
         {bus.RegWrite_EX, bus.MemRead_EX, bus.MemWrite_EX, bus.MemToReg_EX,
          bus.ALUSrc_EX, bus.Branch_EX, bus.Jump_EX, bus.ALUOp_EX} <= '0;
      end else if (load) begin
         bus.valid_EX    <= live;
         bus.pc_EX       <= bus.pc_ID;
         bus.rs1_data_EX <= bus.rs1_data_ID;
         bus.rs2_data_EX <= bus.rs2_data_ID;
         bus.imm_EX      <= bus.imm_ID;
         bus.rs1_EX      <= bus.rs1_ID;
         bus.rs2_EX      <= bus.rs2_ID;
         bus.rd_EX       <= live ? bus.rd_ID : 5'd0;
         bus.funct_EX    <= bus.funct_ID;
         {bus.RegWrite_EX, bus.MemRead_EX, bus.MemWrite_EX, bus.MemToReg_EX,
          bus.ALUSrc_EX, bus.Branch_EX, bus.Jump_EX, bus.ALUOp_EX} <= live ? bus.ctrl_ID : 9'd0;
      end
   end
   // saturating debug counters; hold freezes the bubble counter, flush always counts
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.bubble_cnt <= '0;
         bus.flush_cnt  <= '0;
      end else begin
         if (bump_b) bus.bubble_cnt <= bus.bubble_cnt + CNT_W'(1);
         if (bump_f) bus.flush_cnt  <= bus.flush_cnt + CNT_W'(1);
      end
   end
endmodule

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg

Overview:
- ID/EX pipeline register that consumes the load-use hazard controls.
- Captures decoded control, operands and register addresses from ID each cycle.
- Inserts a bubble when the hazard unit asserts Ctrl, holds on stall, and clears on branch flush.
- Returns MemRead_EX and rd_EX back to the hazard unit, closing the load-use loop; also keeps saturating bubble/flush event counters for debug.

Parameters:
- XLEN, 32, datapath width of pc, operands and immediate
- CNT_W, 16, width of the bubble and flush event counters

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- Ctrl  input  1  bubble request from hazard detection (load-use)
- hold  input  1  freeze whole register (downstream multi-cycle stall)
- flush  input  1  branch/jump taken in EX; kill ID instruction
- valid_ID  input  1  ID holds a real instruction
- pc_ID  input  XLEN  instruction PC
- rs1_data_ID, rs2_data_ID  input  XLEN  register file reads
- imm_ID  input  XLEN  sign-extended immediate
- rs1_ID, rs2_ID, rd_ID  input  5  register addresses
- ctrl_ID  input  9  {RegWrite, MemRead, MemWrite, MemToReg, ALUSrc, Branch, Jump, ALUOp[1:0]}
- funct_ID  input  4  {funct7[5], funct3}
- valid_EX  output  1  EX holds a real instruction
- pc_EX, rs1_data_EX, rs2_data_EX, imm_EX  output  XLEN  registered copies
- rs1_EX, rs2_EX, rd_EX  output  5  registered addresses (rd_EX to hazard unit/forwarding)
- RegWrite_EX, MemRead_EX, MemWrite_EX, MemToReg_EX, ALUSrc_EX, Branch_EX, Jump_EX  output  1 each
- ALUOp_EX  output  2
- funct_EX  output  4
- bubble_cnt, flush_cnt  output  CNT_W  saturating event counters

Behaviour:
- Reset (rst_n low, asynchronous): every output goes to 0, including the counters. Release is synchronous to the next clk edge.
- Latency: ID inputs appear on the EX outputs one clk edge after capture.
- Per-edge priority: flush > hold > Ctrl > normal load.
- flush=1:
  - valid_EX=0; all seven control bits and ALUOp_EX=0; rd_EX=0.
  - Data/address fields other than rd_EX are don't-care (implementation loads them).
  - flush_cnt+1.
  - Ctrl and hold are ignored that cycle.
- hold=1 (no flush): every register, including the counters, keeps its value; Ctrl is ignored.
- Ctrl=1 (no flush/hold), bubble:
  - valid_EX=0; control bits and ALUOp_EX=0; rd_EX=0, so the hazard unit cannot re-trigger on the bubble.
  - Other data fields load normally.
  - bubble_cnt+1.
- Normal: all fields load from ID. If valid_ID=0, the control bits and rd_EX are forced to 0, the same as a bubble but without counting.
- Counters saturate at all-ones with no wrap. Each counter increments at most once per edge.
- No combinational path from any input to any output.
- The hazard unit drops Ctrl the cycle after a bubble because MemRead_EX is 0; the block relies on no other handshake.

Test Plan:
- Reset mid-operation: load pc_ID=0x100, then assert rst_n=0 between clock edges → all outputs 0 immediately, before the next edge; counters 0.
- Normal load: valid_ID=1, pc_ID=0x40, rd_ID=5, ctrl_ID=9'b110000000 → next edge valid_EX=1, pc_EX=0x40, rd_EX=5, RegWrite_EX=1, MemRead_EX=1.
- Load-use bubble: EX holds a load with rd_EX=3; drive Ctrl=1 for one cycle with rd_ID=7 and RegWrite set → valid_EX=0, RegWrite_EX=0, MemRead_EX=0, rd_EX=0, bubble_cnt=1. On the next cycle with Ctrl=0 the instruction loads with rd_EX=7.
- Priority: assert flush=1, hold=1 and Ctrl=1 on the same edge → flush_cnt+1, bubble_cnt unchanged, valid_EX=0. Then hold=1 alone for 3 cycles → all outputs frozen, counters unchanged.
- Saturation: with CNT_W=4, apply Ctrl=1 for 20 cycles → bubble_cnt counts up to 15 and stays at 15. Same check for flush_cnt.
- Invalid ID: valid_ID=0 with ctrl_ID all ones and rd_ID=9 → control bits 0, rd_EX=0, valid_EX=0, bubble_cnt unchanged.
